// File: rtl/mouse_pkg.sv
// Shared constants for the PS/2 mouse packet tracker: FSM encodings,
// packet bit positions, default limits and a magnitude helper.
package mouse_pkg;

  typedef logic [1:0] state_t;

  localparam state_t WAIT_B1 = 2'd0;
  localparam state_t WAIT_B2 = 2'd1;
  localparam state_t WAIT_B3 = 2'd2;
  localparam state_t UPDATE  = 2'd3;

  // Bit positions inside byte 1 of a standard 3-byte mouse packet
  localparam int SYNC_BIT   = 3;
  localparam int SIGN_X_BIT = 4;
  localparam int SIGN_Y_BIT = 5;
  localparam int OVF_X_BIT  = 6;
  localparam int OVF_Y_BIT  = 7;

  localparam logic [7:0] DEFAULT_MAX_X  = 8'd159;
  localparam logic [7:0] DEFAULT_MAX_Y  = 8'd119;
  localparam logic [7:0] DEFAULT_INIT_X = 8'd80;
  localparam logic [7:0] DEFAULT_INIT_Y = 8'd60;
  localparam int         DEFAULT_TIMEOUT_CYCLES = 2_000_000;

  // |delta| saturated to 8 bits; -256 maps to 255
  function automatic logic [7:0] sat_mag(input logic signed [9:0] delta);
    logic signed [9:0] abs_v;
    abs_v = (delta < 10'sd0) ? -delta : delta;
    sat_mag = (abs_v > 10'sd255) ? 8'd255 : abs_v[7:0];
  endfunction

endpackage

// File: rtl/mouse_axis_update.sv
// One axis of the position update: builds the signed delta from the raw
// byte, sign and overflow bits, applies it (optionally inverted) to the
// current position and clamps to [0, max_pos]. Purely combinational.
module mouse_axis_update
  import mouse_pkg::*;
(
  input  logic [7:0] pos,
  input  logic [7:0] raw,
  input  logic       sign,
  input  logic       ovf,
  input  logic       invert,
  input  logic [7:0] max_pos,
  output logic [7:0] next_pos,
  output logic [7:0] mag
);

  logic signed [9:0] delta;
  logic signed [9:0] step;
  logic signed [9:0] sum;

  // Delta decode, position add and clamp
  always_comb begin
    if (ovf) begin
      delta = sign ? -10'sd256 : 10'sd255;
    end else begin
      delta = {sign, sign, raw};
    end
    // Y grows downwards on screen while the mouse reports up as positive
    step = invert ? -delta : delta;
    sum  = $signed({2'b00, pos}) + step;
    if (sum < 10'sd0) begin
      next_pos = 8'd0;
    end else if (sum > $signed({2'b00, max_pos})) begin
      next_pos = max_pos;
    end else begin
      next_pos = sum[7:0];
    end
    mag = sat_mag(delta);
  end

endmodule

// File: rtl/mouse_packet_tracker.sv
// Assembles 3-byte PS/2 mouse packets, tracks a clamped absolute cursor
// position and reports accepted/discarded packets with one-cycle pulses.
module mouse_packet_tracker
  import mouse_pkg::*;
#(
  parameter logic [7:0] MAX_X          = DEFAULT_MAX_X,
  parameter logic [7:0] MAX_Y          = DEFAULT_MAX_Y,
  parameter logic [7:0] INIT_X         = DEFAULT_INIT_X,
  parameter logic [7:0] INIT_Y         = DEFAULT_INIT_Y,
  parameter int         TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic       CLK_100,
  input  logic       RESET,
  input  logic [7:0] BYTE_IN,
  input  logic       BYTE_READY,
  input  logic       BYTE_ERR,
  output logic [3:0] MOUSE_STATUS,
  output logic [7:0] MOUSE_X,
  output logic [7:0] MOUSE_Y,
  output logic [7:0] MOUSE_MOVE_X,
  output logic [7:0] MOUSE_MOVE_Y,
  output logic       SEND_INTERRUPT,
  output logic       PACKET_ERR
);

  localparam int              GAP_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [GAP_W-1:0] GAP_LIMIT = GAP_W'(TIMEOUT_CYCLES);

  state_t           state_reg, state_next;
  logic [7:0]       byte1_reg, byte1_next;
  logic [7:0]       dx_raw_reg, dx_raw_next;
  logic [7:0]       dy_raw_reg, dy_raw_next;
  logic [GAP_W-1:0] gap_cnt_reg, gap_cnt_next;
  logic             err_now;
  logic             err_pend_reg;
  logic             send_int_reg;
  logic             pkt_err_reg;
  logic [3:0]       status_reg;
  logic [7:0]       pos_reg  [2];
  logic [7:0]       move_reg [2];
  logic [7:0]       next_pos_w [2];
  logic [7:0]       mag_w      [2];

  // Index 0 is X, index 1 is Y (inverted so that Y = 0 is the top row)
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_axis
      localparam int SIGN_BIT = (gi == 0) ? SIGN_X_BIT : SIGN_Y_BIT;
      localparam int OVF_BIT  = (gi == 0) ? OVF_X_BIT  : OVF_Y_BIT;
      mouse_axis_update u_axis (
        .pos      (pos_reg[gi]),
        .raw      ((gi == 0) ? dx_raw_reg : dy_raw_reg),
        .sign     (byte1_reg[SIGN_BIT]),
        .ovf      (byte1_reg[OVF_BIT]),
        .invert   ((gi == 0) ? 1'b0 : 1'b1),
        .max_pos  ((gi == 0) ? MAX_X : MAX_Y),
        .next_pos (next_pos_w[gi]),
        .mag      (mag_w[gi])
      );
    end
  endgenerate

  // Packet FSM next-state, byte latching and inter-byte gap counting
  always_comb begin
    state_next   = state_reg;
    byte1_next   = byte1_reg;
    dx_raw_next  = dx_raw_reg;
    dy_raw_next  = dy_raw_reg;
    gap_cnt_next = gap_cnt_reg;
    err_now      = 1'b0;
    case (state_reg)
      WAIT_B2, WAIT_B3: begin
        if (BYTE_ERR) begin
          err_now      = 1'b1;
          state_next   = WAIT_B1;
          gap_cnt_next = '0;
        end else if (gap_cnt_reg >= GAP_LIMIT) begin
          err_now      = 1'b1;
          state_next   = WAIT_B1;
          gap_cnt_next = '0;
        end else if (BYTE_READY) begin
          gap_cnt_next = '0;
          if (state_reg == WAIT_B2) begin
            dx_raw_next = BYTE_IN;
            state_next  = WAIT_B3;
          end else begin
            dy_raw_next = BYTE_IN;
            state_next  = UPDATE;
          end
        end else begin
          gap_cnt_next = gap_cnt_reg + GAP_W'(1);
        end
      end
      default: begin
        // WAIT_B1 and UPDATE both treat an incoming byte as byte 1
        state_next   = WAIT_B1;
        gap_cnt_next = '0;
        if (BYTE_ERR) begin
          err_now = 1'b1;
        end else if (BYTE_READY) begin
          if (BYTE_IN[SYNC_BIT]) begin
            byte1_next = BYTE_IN;
            state_next = WAIT_B2;
          end else begin
            err_now = 1'b1;
          end
        end
      end
    endcase
  end

  // Control state; an error raised while in UPDATE is delayed one cycle so
  // it never overlaps the interrupt pulse issued on leaving UPDATE
  always_ff @(posedge CLK_100) begin
    if (RESET) begin
      state_reg    <= WAIT_B1;
      byte1_reg    <= 8'd0;
      dx_raw_reg   <= 8'd0;
      dy_raw_reg   <= 8'd0;
      gap_cnt_reg  <= '0;
      err_pend_reg <= 1'b0;
      send_int_reg <= 1'b0;
      pkt_err_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      byte1_reg    <= byte1_next;
      dx_raw_reg   <= dx_raw_next;
      dy_raw_reg   <= dy_raw_next;
      gap_cnt_reg  <= gap_cnt_next;
      err_pend_reg <= err_now && (state_reg == UPDATE);
      send_int_reg <= (state_reg == UPDATE);
      pkt_err_reg  <= (err_now && (state_reg != UPDATE)) || err_pend_reg;
    end
  end

  // Visible packet results change only on the edge leaving UPDATE
  always_ff @(posedge CLK_100) begin
    if (RESET) begin
      status_reg  <= 4'h0;
      pos_reg[0]  <= INIT_X;
      pos_reg[1]  <= INIT_Y;
      move_reg[0] <= 8'd0;
      move_reg[1] <= 8'd0;
    end else if (state_reg == UPDATE) begin
      status_reg  <= byte1_reg[3:0];
      pos_reg[0]  <= next_pos_w[0];
      pos_reg[1]  <= next_pos_w[1];
      move_reg[0] <= mag_w[0];
      move_reg[1] <= mag_w[1];
    end
  end

  assign MOUSE_STATUS   = status_reg;
  assign MOUSE_X        = pos_reg[0];
  assign MOUSE_Y        = pos_reg[1];
  assign MOUSE_MOVE_X   = move_reg[0];
  assign MOUSE_MOVE_Y   = move_reg[1];
  assign SEND_INTERRUPT = send_int_reg;
  assign PACKET_ERR     = pkt_err_reg;

endmodule

// File: tb/tb_mouse_packet_tracker.sv
// Directed bench for mouse_packet_tracker: a table of packets applied
// back to back, then hand-written sequences for resync, timeout, byte
// errors, mid-packet reset and bytes arriving during UPDATE.
module tb_mouse_packet_tracker;

  localparam int TB_TIMEOUT = 50;

  logic       CLK_100 = 1'b0;
  logic       RESET;
  logic [7:0] BYTE_IN;
  logic       BYTE_READY;
  logic       BYTE_ERR;
  logic [3:0] MOUSE_STATUS;
  logic [7:0] MOUSE_X;
  logic [7:0] MOUSE_Y;
  logic [7:0] MOUSE_MOVE_X;
  logic [7:0] MOUSE_MOVE_Y;
  logic       SEND_INTERRUPT;
  logic       PACKET_ERR;

  int checks   = 0;
  int failures = 0;
  int int_cnt  = 0;
  int err_cnt  = 0;
  int both_cnt = 0;
  int base_int;
  int base_err;

  typedef struct {
    logic [7:0] b1;
    logic [7:0] b2;
    logic [7:0] b3;
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] mx;
    logic [7:0] my;
    logic [3:0] st;
  } vec_t;

  vec_t vecs [10];

  mouse_packet_tracker #(
    .TIMEOUT_CYCLES (TB_TIMEOUT)
  ) dut (
    .CLK_100        (CLK_100),
    .RESET          (RESET),
    .BYTE_IN        (BYTE_IN),
    .BYTE_READY     (BYTE_READY),
    .BYTE_ERR       (BYTE_ERR),
    .MOUSE_STATUS   (MOUSE_STATUS),
    .MOUSE_X        (MOUSE_X),
    .MOUSE_Y        (MOUSE_Y),
    .MOUSE_MOVE_X   (MOUSE_MOVE_X),
    .MOUSE_MOVE_Y   (MOUSE_MOVE_Y),
    .SEND_INTERRUPT (SEND_INTERRUPT),
    .PACKET_ERR     (PACKET_ERR)
  );

  always #5 CLK_100 = ~CLK_100;

  // Pulse bookkeeping
  always @(posedge CLK_100) begin
    if (SEND_INTERRUPT) int_cnt <= int_cnt + 1;
    if (PACKET_ERR) err_cnt <= err_cnt + 1;
    if (SEND_INTERRUPT && PACKET_ERR) both_cnt <= both_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // All stimulus tasks start and end on a falling edge
  task automatic idle(input int n);
    repeat (n) @(negedge CLK_100);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic err);
    BYTE_IN    = b;
    BYTE_READY = 1'b1;
    BYTE_ERR   = err;
    @(negedge CLK_100);
    BYTE_READY = 1'b0;
    BYTE_ERR   = 1'b0;
  endtask

  task automatic send_packet(input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3);
    send_byte(b1, 1'b0);
    send_byte(b2, 1'b0);
    send_byte(b3, 1'b0);
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    @(negedge CLK_100);
    RESET = 1'b0;
  endtask

  // Called right after byte 3 was sampled: interrupt must appear one edge later
  task automatic check_packet(input string name, input logic [7:0] ex, input logic [7:0] ey,
                              input logic [7:0] emx, input logic [7:0] emy, input logic [3:0] est);
    check({name, "_si_early"}, SEND_INTERRUPT, 0);
    @(negedge CLK_100);
    check({name, "_si"}, SEND_INTERRUPT, 1);
    check({name, "_pe"}, PACKET_ERR, 0);
    check({name, "_x"}, MOUSE_X, ex);
    check({name, "_y"}, MOUSE_Y, ey);
    check({name, "_mx"}, MOUSE_MOVE_X, emx);
    check({name, "_my"}, MOUSE_MOVE_Y, emy);
    check({name, "_st"}, MOUSE_STATUS, est);
    $display("PKT %s x=%0d y=%0d mx=%0d my=%0d st=%h", name, MOUSE_X, MOUSE_Y,
             MOUSE_MOVE_X, MOUSE_MOVE_Y, MOUSE_STATUS);
  endtask

  initial begin
    vecs[0] = '{8'h08, 8'h05, 8'h03, 8'd85,  8'd57,  8'd5,   8'd3,   4'h8};
    vecs[1] = '{8'h18, 8'hB0, 8'h00, 8'd5,   8'd57,  8'd80,  8'd0,   4'h8};
    vecs[2] = '{8'h18, 8'hF6, 8'h00, 8'd0,   8'd57,  8'd10,  8'd0,   4'h8};
    vecs[3] = '{8'h48, 8'h10, 8'h00, 8'd159, 8'd57,  8'd255, 8'd0,   4'h8};
    vecs[4] = '{8'h28, 8'h00, 8'hFF, 8'd159, 8'd58,  8'd0,   8'd1,   4'h8};
    vecs[5] = '{8'h88, 8'h00, 8'h00, 8'd159, 8'd0,   8'd0,   8'd255, 4'h8};
    vecs[6] = '{8'hA8, 8'h00, 8'h00, 8'd159, 8'd119, 8'd0,   8'd255, 4'h8};
    vecs[7] = '{8'h0F, 8'h02, 8'h01, 8'd159, 8'd118, 8'd2,   8'd1,   4'hF};
    vecs[8] = '{8'h58, 8'h00, 8'h00, 8'd0,   8'd118, 8'd255, 8'd0,   4'h8};
    vecs[9] = '{8'h1B, 8'hFF, 8'h00, 8'd0,   8'd118, 8'd1,   8'd0,   4'hB};

    RESET      = 1'b1;
    BYTE_IN    = 8'h00;
    BYTE_READY = 1'b0;
    BYTE_ERR   = 1'b0;
    idle(3);
    RESET = 1'b0;
    idle(1);
    check("rst_x", MOUSE_X, 80);
    check("rst_y", MOUSE_Y, 60);
    check("rst_st", MOUSE_STATUS, 0);
    check("rst_mx", MOUSE_MOVE_X, 0);
    check("rst_my", MOUSE_MOVE_Y, 0);
    check("rst_si", SEND_INTERRUPT, 0);
    check("rst_pe", PACKET_ERR, 0);
    $display("RESET x=%0d y=%0d", MOUSE_X, MOUSE_Y);

    // Table: packets applied in order, position carries between vectors
    for (int i = 0; i < 10; i++) begin
      send_packet(vecs[i].b1, vecs[i].b2, vecs[i].b3);
      check_packet($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].mx,
                   vecs[i].my, vecs[i].st);
      idle(1);
    end

    // Non-sync byte is rejected, then a good packet is taken
    do_reset();
    send_byte(8'h00, 1'b0);
    check("resync_pe", PACKET_ERR, 1);
    check("resync_si", SEND_INTERRUPT, 0);
    idle(1);
    send_packet(8'h09, 8'h01, 8'h01);
    check_packet("resync", 8'd81, 8'd59, 8'd1, 8'd1, 4'h9);

    // Gaps shorter than the timeout are tolerated
    do_reset();
    idle(2);
    base_err = err_cnt;
    send_byte(8'h08, 1'b0);
    idle(40);
    send_byte(8'h05, 1'b0);
    idle(40);
    send_byte(8'h03, 1'b0);
    check_packet("slowgap", 8'd85, 8'd57, 8'd5, 8'd3, 4'h8);
    idle(3);
    check("slowgap_noerr", err_cnt - base_err, 0);

    // Gap longer than the timeout drops the partial packet
    do_reset();
    idle(2);
    send_byte(8'h08, 1'b0);
    send_byte(8'h05, 1'b0);
    base_int = int_cnt;
    base_err = err_cnt;
    idle(3 * TB_TIMEOUT);
    check("timeout_err", err_cnt - base_err, 1);
    check("timeout_int", int_cnt - base_int, 0);
    check("timeout_x", MOUSE_X, 80);
    check("timeout_st", MOUSE_STATUS, 0);
    $display("TIMEOUT errs=%0d", err_cnt - base_err);
    send_packet(8'h08, 8'h01, 8'h00);
    check_packet("after_to", 8'd81, 8'd60, 8'd1, 8'd0, 4'h8);

    // BYTE_ERR together with BYTE_READY in WAIT_B2 discards the packet
    do_reset();
    send_byte(8'h08, 1'b0);
    send_byte(8'h05, 1'b1);
    check("byteerr_pe", PACKET_ERR, 1);
    idle(2);
    check("byteerr_x", MOUSE_X, 80);
    check("byteerr_mx", MOUSE_MOVE_X, 0);
    send_packet(8'h08, 8'h01, 8'h00);
    check_packet("after_be", 8'd81, 8'd60, 8'd1, 8'd0, 4'h8);

    // Reset in the middle of a packet: no error pulse, state restored
    do_reset();
    send_packet(8'h08, 8'h05, 8'h03);
    check_packet("pre_rst", 8'd85, 8'd57, 8'd5, 8'd3, 4'h8);
    idle(3);
    base_int = int_cnt;
    base_err = err_cnt;
    send_byte(8'h08, 1'b0);
    send_byte(8'h05, 1'b0);
    do_reset();
    idle(3);
    check("midrst_x", MOUSE_X, 80);
    check("midrst_y", MOUSE_Y, 60);
    check("midrst_mx", MOUSE_MOVE_X, 0);
    check("midrst_err", err_cnt - base_err, 0);
    check("midrst_int", int_cnt - base_int, 0);
    send_packet(8'h08, 8'h05, 8'h03);
    check_packet("post_rst", 8'd85, 8'd57, 8'd5, 8'd3, 4'h8);

    // Non-sync byte arriving in UPDATE: error follows the interrupt
    do_reset();
    send_packet(8'h08, 8'h02, 8'h00);
    send_byte(8'h00, 1'b0);
    check("upd_si", SEND_INTERRUPT, 1);
    check("upd_pe_early", PACKET_ERR, 0);
    check("upd_x", MOUSE_X, 82);
    @(negedge CLK_100);
    check("upd_pe", PACKET_ERR, 1);
    check("upd_si_after", SEND_INTERRUPT, 0);
    idle(2);

    // Sync byte arriving in UPDATE starts the next packet
    send_packet(8'h08, 8'h02, 8'h00);
    send_packet(8'h08, 8'h03, 8'h00);
    check_packet("b2b", 8'd87, 8'd60, 8'd3, 8'd0, 4'h8);
    idle(3);

    check("no_overlap", both_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
